// File: rtl/intc_apb_prio_v2_if.sv
// APB slave-side bus bundle for the priority interrupt controller.
interface intc_apb_prio_v2_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  psel_i;
    logic                  penable_i;
    logic                  pwrite_i;
    logic [ADDR_WIDTH-1:0] paddr_i;
    logic [DATA_WIDTH-1:0] pwdata_i;
    logic [DATA_WIDTH-1:0] prdata_o;
    logic                  pready_o;
    logic                  perror_o;

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        input  prdata_o, pready_o, perror_o
    );

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        output prdata_o, pready_o, perror_o
    );
endinterface

// File: rtl/intc_apb_prio_v2.sv
// APB-programmable interrupt controller: per-source priority/enable/edge mode,
// presents one winning ID at a time and holds it until acknowledged.
module intc_apb_prio_v2 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_INTR   = 16,
    parameter int INTR_SERV  = 4
) (
    input  logic                 pclk_i,
    input  logic                 presetn_i,
    intc_apb_prio_v2_if.slave    apb,
    input  logic [NUM_INTR-1:0]  intr_active_i,
    output logic                 intr_valid_o,
    output logic [INTR_SERV-1:0] intr_to_service_o,
    input  logic                 intr_serviced_i
);
    typedef enum logic [1:0] {IDLE, ARB, VALID, CLR} state_t;

    state_t                state_q, state_d;
    logic [INTR_SERV-1:0]  id_q, id_d;

    logic [INTR_SERV-1:0]  prio [NUM_INTR];
    logic [NUM_INTR-1:0]   en, edg_md, edg_lat, line_q;
    logic [NUM_INTR-1:0]   pend, elig, rise, clr_mask;

    logic                  pready_q, perr_q, wr_prio_q, wr_cfg_q;
    logic [DATA_WIDTH-1:0] prdata_q, wdata_q, rd;
    logic [5:0]            idx_q, idx;
    logic                  access, err, is_prio, is_cfg, is_stat;
    logic [DATA_WIDTH+7:0] stat;

    logic                  any_elig;
    logic [INTR_SERV-1:0]  win_id, best_prio;

    // ---------------- APB decode ----------------
    // pready_q gates access so the completion cycle never starts a new transfer
    assign access  = apb.psel_i & apb.penable_i & ~pready_q;
    assign idx     = apb.paddr_i[5:0];
    assign is_prio = ((apb.paddr_i >> 6) == '0) && (int'(idx) < NUM_INTR);
    assign is_cfg  = ((apb.paddr_i >> 6) == ADDR_WIDTH'(1)) && (int'(idx) < NUM_INTR);
    assign is_stat = (apb.paddr_i == ADDR_WIDTH'(8'h80));

    always_comb begin
        rd   = '0;
        err  = 1'b1;
        stat = '0;
        if (is_prio) begin
            err = 1'b0;
            for (int i = 0; i < NUM_INTR; i++)
                if (idx == 6'(i)) rd[INTR_SERV-1:0] = prio[i];
        end else if (is_cfg) begin
            err = 1'b0;
            for (int i = 0; i < NUM_INTR; i++)
                if (idx == 6'(i)) rd[2:0] = {pend[i], edg_md[i], en[i]};
        end else if (is_stat) begin
            err                  = apb.pwrite_i;
            stat[7]              = intr_valid_o;
            stat[INTR_SERV-1:0]  = intr_to_service_o;
            rd                   = stat[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            pready_q  <= 1'b0;
            perr_q    <= 1'b0;
            prdata_q  <= '0;
            wr_prio_q <= 1'b0;
            wr_cfg_q  <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
        end else begin
            pready_q  <= access;
            perr_q    <= access & err;
            prdata_q  <= (access & ~apb.pwrite_i) ? rd : '0;
            wr_prio_q <= access & apb.pwrite_i & is_prio;
            wr_cfg_q  <= access & apb.pwrite_i & is_cfg;
            if (access) begin
                idx_q   <= idx;
                wdata_q <= apb.pwdata_i;
            end
        end
    end

    assign apb.pready_o = pready_q;
    assign apb.perror_o = perr_q;
    assign apb.prdata_o = prdata_q;

    // ---------------- sources ----------------
    assign rise = intr_active_i & ~line_q;
    assign pend = (edg_md & edg_lat) | (~edg_md & intr_active_i);
    assign elig = pend & en;

    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < NUM_INTR; i++)
            clr_mask[i] = (state_q == CLR) && (id_q == INTR_SERV'(i));
    end

    // register writes commit on the pready cycle (flags are one cycle late)
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            for (int i = 0; i < NUM_INTR; i++) prio[i] <= '0;
            en      <= '0;
            edg_md  <= '0;
            edg_lat <= '0;
            line_q  <= '0;
        end else begin
            line_q  <= intr_active_i;
            // set beats clear so an edge arriving during CLR is not lost
            edg_lat <= (edg_md & rise) | (edg_lat & ~clr_mask);
            for (int i = 0; i < NUM_INTR; i++) begin
                if (wr_prio_q && idx_q == 6'(i)) prio[i] <= wdata_q[INTR_SERV-1:0];
                if (wr_cfg_q && idx_q == 6'(i)) begin
                    en[i]     <= wdata_q[0];
                    edg_md[i] <= wdata_q[1];
                end
            end
        end
    end

    // ---------------- arbitration: highest prio, lowest index on ties ----------------
    always_comb begin
        any_elig  = 1'b0;
        win_id    = '0;
        best_prio = '0;
        for (int i = 0; i < NUM_INTR; i++) begin
            if (elig[i] && (!any_elig || prio[i] > best_prio)) begin
                any_elig  = 1'b1;
                win_id    = INTR_SERV'(i);
                best_prio = prio[i];
            end
        end
    end

    // ---------------- service FSM ----------------
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_q <= IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE:  if (any_elig) state_d = ARB;
            ARB: begin
                if (any_elig) begin
                    id_d    = win_id;
                    state_d = VALID;
                end else begin
                    state_d = IDLE;
                end
            end
            VALID: if (intr_serviced_i) state_d = CLR;
            CLR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign intr_valid_o      = (state_q == VALID);
    assign intr_to_service_o = intr_valid_o ? id_q : '0;

    logic unused_bits;
    assign unused_bits = ^{wdata_q, stat};
endmodule

// File: tb/tb_intc_apb_prio_v2.sv
// Directed bench for intc_apb_prio_v2: register-map vector table plus service sequences.
module tb_intc_apb_prio_v2;
    logic        pclk_i = 1'b0;
    logic        presetn_i = 1'b0;
    logic [15:0] lines = '0;
    logic        ack = 1'b0;
    logic        intr_valid_o;
    logic [3:0]  intr_to_service_o;
    int          checks = 0;
    int          failures = 0;

    intc_apb_prio_v2_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) apb();

    intc_apb_prio_v2 #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_INTR(16), .INTR_SERV(4)) dut (
        .pclk_i            (pclk_i),
        .presetn_i         (presetn_i),
        .apb               (apb),
        .intr_active_i     (lines),
        .intr_valid_o      (intr_valid_o),
        .intr_to_service_o (intr_to_service_o),
        .intr_serviced_i   (ack)
    );

    always #5 pclk_i = ~pclk_i;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        logic       exp_err;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                            output logic [7:0] rd, output logic err);
        bit got;
        got = 1'b0;
        @(posedge pclk_i); #1;
        apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = wr;
        apb.paddr_i = addr; apb.pwdata_i = wd;
        @(posedge pclk_i); #1;
        apb.penable_i = 1'b1;
        for (int n = 0; n < 4 && !got; n++) begin
            @(posedge pclk_i); #1;
            if (apb.pready_o) got = 1'b1;
        end
        rd  = apb.prdata_o;
        err = apb.perror_o;
        if (!got) begin
            checks++; failures++;
            $display("FAIL pready_timeout addr=%0h", addr);
        end
        apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] addr, input logic [7:0] wd);
        logic [7:0] rd; logic err;
        apb_xfer(1'b1, addr, wd, rd, err);
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] rd; logic err;
        apb_xfer(1'b0, addr, 8'h00, rd, err);
        chk(nm, {23'd0, err, rd}, {23'd0, 1'b0, exp});
    endtask

    task automatic wait_valid(input string nm, input int exp_id);
        for (int n = 0; n < 30 && !intr_valid_o; n++) begin
            @(posedge pclk_i); #1;
        end
        chk(nm, {27'd0, intr_valid_o, intr_to_service_o}, {27'd0, 1'b1, 4'(exp_id)});
    endtask

    task automatic hold_chk(input string nm, input int exp_id);
        repeat (3) begin @(posedge pclk_i); #1; end
        chk(nm, {27'd0, intr_valid_o, intr_to_service_o}, {27'd0, 1'b1, 4'(exp_id)});
    endtask

    task automatic ack_it(input string nm, input int id);
        lines[id] = 1'b0;
        ack = 1'b1;
        @(posedge pclk_i); #1;
        ack = 1'b0;
        chk(nm, {31'd0, intr_valid_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd; logic err;
        apb.psel_i = 0; apb.penable_i = 0; apb.pwrite_i = 0; apb.paddr_i = 0; apb.pwdata_i = 0;

        vecs[0]  = '{1'b1, 8'h03, 8'hFA, 8'h00, 1'b0}; // PRIO upper bits dropped
        vecs[1]  = '{1'b0, 8'h03, 8'h00, 8'h0A, 1'b0};
        vecs[2]  = '{1'b1, 8'h44, 8'hFF, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 8'h44, 8'h00, 8'h03, 1'b0}; // EN|EDGE, PEND=0
        vecs[4]  = '{1'b0, 8'h20, 8'h00, 8'h00, 1'b1};
        vecs[5]  = '{1'b1, 8'h80, 8'h55, 8'h00, 1'b1};
        vecs[6]  = '{1'b0, 8'h80, 8'h00, 8'h00, 1'b0}; // STAT unchanged
        vecs[7]  = '{1'b0, 8'h50, 8'h00, 8'h00, 1'b1};
        vecs[8]  = '{1'b1, 8'h45, 8'h02, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, 8'h45, 8'h00, 8'h02, 1'b0};
        vecs[10] = '{1'b0, 8'h81, 8'h00, 8'h00, 1'b1};
        vecs[11] = '{1'b1, 8'h13, 8'h01, 8'h00, 1'b1};

        #1;
        chk("reset_outputs", {apb.pready_o, apb.perror_o, apb.prdata_o, intr_valid_o, intr_to_service_o},
            32'd0);
        repeat (2) @(posedge pclk_i);
        #1 presetn_i = 1'b1;

        foreach (vecs[k]) begin
            apb_xfer(vecs[k].wr, vecs[k].addr, vecs[k].wdata, rd, err);
            chk($sformatf("vec%0d_err", k), {31'd0, err}, {31'd0, vecs[k].exp_err});
            if (!vecs[k].wr)
                chk($sformatf("vec%0d_rd", k), {24'd0, rd}, {24'd0, vecs[k].exp_rd});
        end

        // ascending priority: 7,5,2,0
        for (int i = 0; i < 16; i++) begin
            wr_reg(8'(i), 8'(i));
            wr_reg(8'h40 + 8'(i), 8'h01);
        end
        @(posedge pclk_i); #1;
        lines = 16'h00A5;
        @(posedge pclk_i); #1;
        chk("lat_cycle1", {31'd0, intr_valid_o}, 32'd0);
        @(posedge pclk_i); #1;
        chk("lat_cycle2", {27'd0, intr_valid_o, intr_to_service_o}, {27'd0, 1'b1, 4'd7});
        rd_chk("stat_valid7", 8'h80, 8'h87);
        hold_chk("hold7", 7);
        ack_it("clr7", 7);
        wait_valid("asc5", 5); ack_it("clr5", 5);
        wait_valid("asc2", 2); ack_it("clr2", 2);
        wait_valid("asc0", 0); ack_it("clr0", 0);

        // descending priority: 0,2,5,7
        for (int i = 0; i < 16; i++) wr_reg(8'(i), 8'(15 - i));
        lines = 16'h00A5;
        wait_valid("desc0", 0); hold_chk("hold0", 0); ack_it("dclr0", 0);
        wait_valid("desc2", 2); ack_it("dclr2", 2);
        wait_valid("desc5", 5); ack_it("dclr5", 5);
        wait_valid("desc7", 7); ack_it("dclr7", 7);

        // equal priority tie, then edge pulse
        wr_reg(8'h03, 8'h06);
        wr_reg(8'h09, 8'h06);
        lines[3] = 1'b1; lines[9] = 1'b1;
        wait_valid("tie3", 3); ack_it("tclr3", 3);
        wait_valid("tie9", 9); ack_it("tclr9", 9);
        wr_reg(8'h49, 8'h03);
        @(posedge pclk_i); #1 lines[9] = 1'b1;
        @(posedge pclk_i); #1 lines[9] = 1'b0;
        wait_valid("edge9", 9);
        rd_chk("pend9_set", 8'h49, 8'h07);
        ack_it("eclr9", 9);
        rd_chk("pend9_clr", 8'h49, 8'h03);
        repeat (5) @(posedge pclk_i); #1;
        chk("edge_once", {31'd0, intr_valid_o}, 32'd0);

        // no retraction: disable presented source, raise higher one
        wr_reg(8'h49, 8'h01);
        lines[5] = 1'b1;
        wait_valid("keep5", 5);
        wr_reg(8'h45, 8'h00);
        lines[0] = 1'b1;
        hold_chk("still5", 5);
        ack_it("kclr5", 5);
        wait_valid("then0", 0); ack_it("kclr0", 0);

        // reset during VALID
        lines[2] = 1'b1;
        wait_valid("pre_rst2", 2);
        #2 presetn_i = 1'b0;
        #1 chk("rst_valid", {27'd0, intr_valid_o, intr_to_service_o}, 32'd0);
        lines = '0;
        @(posedge pclk_i); #1 presetn_i = 1'b1;

        // reset during APB access phase
        @(posedge pclk_i); #1;
        apb.psel_i = 1'b1; apb.pwrite_i = 1'b0; apb.paddr_i = 8'h00;
        @(posedge pclk_i); #1;
        apb.penable_i = 1'b1;
        #2 presetn_i = 1'b0;
        #1 chk("rst_apb_now", {apb.pready_o, apb.perror_o, apb.prdata_o}, 32'd0);
        @(posedge pclk_i); #1;
        chk("rst_apb_drop", {apb.pready_o, apb.perror_o, apb.prdata_o}, 32'd0);
        apb.psel_i = 1'b0; apb.penable_i = 1'b0;
        presetn_i = 1'b1;
        rd_chk("prio0_after_rst", 8'h00, 8'h00);
        rd_chk("cfg2_after_rst", 8'h42, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
